// File: rtl/seq_pkg.sv
// Shared types and constants for the seven-state one-hot sequencer.
package seq_pkg;

  localparam int NUM_STATES = 7;

  typedef logic [NUM_STATES-1:0] state_oh_t;

  localparam state_oh_t S0_OH = 7'b000_0001;
  localparam state_oh_t S1_OH = 7'b000_0010;
  localparam state_oh_t S2_OH = 7'b000_0100;
  localparam state_oh_t S3_OH = 7'b000_1000;
  localparam state_oh_t S4_OH = 7'b001_0000;
  localparam state_oh_t S5_OH = 7'b010_0000;
  localparam state_oh_t S6_OH = 7'b100_0000;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input state_oh_t s);
    return (s != '0) && ((s & (s - state_oh_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw active-low pushbutton -> synchronized, debounced, single-cycle press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q, sync_q;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          acc_q, acc_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    lvl     = ~sync_q;
    fill_d  = {fill_q[0], 1'b1};
    // Only arm once the synchronizer holds a real sample showing the key released,
    // so a key held through reset never yields a press.
    armed_d = armed_q | (fill_q[1] & ~lvl);
    acc_d   = acc_q;
    cnt_d   = '0;
    evt_d   = 1'b0;
    if (lvl != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        acc_d = lvl;
        evt_d = lvl & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/state_sequencer.sv
// Seven-state one-hot sequencer stepped by debounced buttons or a timed auto-advance.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_next_n,
  input  logic key_back_n,
  input  logic auto_en,
  output logic state_0,
  output logic state_1,
  output logic state_2,
  output logic state_3,
  output logic state_4,
  output logic state_5,
  output logic state_6,
  output logic step_pulse
);

  localparam int TW = $clog2(STEP_CYCLES);

  logic          next_evt, back_evt;
  logic          auto_meta_q, auto_sync_q;
  logic [TW-1:0] timer_q, timer_d;
  state_oh_t     state_q, state_d;
  logic          moved_q, moved_d;
  logic          step_pulse_q, step_pulse_d;
  logic          auto_evt, btn_evt, go_next, go_back;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_next_n),
    .press_evt (next_evt)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_back_n),
    .press_evt (back_evt)
  );

  always_comb begin
    auto_evt = auto_sync_q && (timer_q == TW'(STEP_CYCLES - 1));
    btn_evt  = next_evt | back_evt;
    timer_d  = (btn_evt || !auto_sync_q || auto_evt) ? '0 : timer_q + TW'(1);
    // Opposing presses cancel; any button press pre-empts a coincident auto step.
    go_next  = (next_evt & ~back_evt) | (auto_evt & ~btn_evt);
    go_back  = back_evt & ~next_evt;

    state_d      = state_q;
    moved_d      = 1'b0;
    step_pulse_d = moved_q;
    if (!is_onehot(state_q)) begin
      state_d = S0_OH;
    end else if (go_next) begin
      state_d = {state_q[NUM_STATES-2:0], state_q[NUM_STATES-1]};
      moved_d = 1'b1;
    end else if (go_back) begin
      state_d = {state_q[0], state_q[NUM_STATES-1:1]};
      moved_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_meta_q  <= 1'b0;
      auto_sync_q  <= 1'b0;
      timer_q      <= '0;
      state_q      <= S0_OH;
      moved_q      <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      auto_meta_q  <= auto_en;
      auto_sync_q  <= auto_meta_q;
      timer_q      <= timer_d;
      state_q      <= state_d;
      moved_q      <= moved_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign state_0    = state_q[0];
  assign state_1    = state_q[1];
  assign state_2    = state_q[2];
  assign state_3    = state_q[3];
  assign state_4    = state_q[4];
  assign state_5    = state_q[5];
  assign state_6    = state_q[6];
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed self-checking bench for state_sequencer with short debounce and step intervals.
module tb_state_sequencer;

  logic clk, rst_n, key_next_n, key_back_n, auto_en;
  logic state_0, state_1, state_2, state_3, state_4, state_5, state_6, step_pulse;
  logic [6:0] st;
  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int base;

  state_sequencer #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_next_n (key_next_n),
    .key_back_n (key_back_n),
    .auto_en    (auto_en),
    .state_0    (state_0),
    .state_1    (state_1),
    .state_2    (state_2),
    .state_3    (state_3),
    .state_4    (state_4),
    .state_5    (state_5),
    .state_6    (state_6),
    .step_pulse (step_pulse)
  );

  assign st = {state_6, state_5, state_4, state_3, state_2, state_1, state_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic nxt, input logic bck, input int hold);
    key_next_n = ~nxt;
    key_back_n = ~bck;
    wait_cyc(hold);
    key_next_n = 1'b1;
    key_back_n = 1'b1;
    wait_cyc(10);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_next_n = 1'b1;
    key_back_n = 1'b1;
    auto_en    = 1'b0;
    wait_cyc(2);
    check("reset_state", 32'(st), 32'h01);
    check("reset_pulse", 32'(step_pulse), 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);
    check("idle_state", 32'(st), 32'h01);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Single press: 2 sync + 4 debounce + 1 edge + 1 register = 8 edges.
    key_next_n = 1'b0;
    wait_cyc(7);
    check("latency_before", 32'(st), 32'h01);
    wait_cyc(1);
    check("latency_s1", 32'(st), 32'h02);
    check("pulse_lag", 32'(step_pulse), 32'h0);
    wait_cyc(1);
    check("pulse_high", 32'(step_pulse), 32'h1);
    wait_cyc(1);
    check("pulse_low", 32'(step_pulse), 32'h0);
    wait_cyc(10);
    key_next_n = 1'b1;
    wait_cyc(10);
    check("single_state", 32'(st), 32'h02);
    check("single_pulses", 32'(pulse_cnt), 32'd1);

    // Bounce for 12 cycles then hold: one step only.
    for (int i = 0; i < 6; i++) begin
      key_next_n = i[0];
      wait_cyc(2);
    end
    key_next_n = 1'b0;
    wait_cyc(12);
    key_next_n = 1'b1;
    wait_cyc(10);
    check("bounce_state", 32'(st), 32'h04);
    check("bounce_pulses", 32'(pulse_cnt), 32'd2);

    press(1'b1, 1'b0, 12);
    check("to_s3", 32'(st), 32'h08);

    // Async reset at S3 with next key held through it.
    key_next_n = 1'b0;
    wait_cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(st), 32'h01);
    check("async_rst_pulse", 32'(step_pulse), 32'h0);
    base = pulse_cnt;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    check("held_thru_rst", 32'(st), 32'h01);
    key_next_n = 1'b1;
    wait_cyc(10);
    check("release_no_step", 32'(st), 32'h01);
    check("rst_no_pulses", 32'(pulse_cnt - base), 32'd0);

    // Seven clean presses walk S1..S6 and wrap to S0.
    base = pulse_cnt;
    for (int k = 1; k <= 7; k++) begin
      logic [6:0] exp_st;
      exp_st = 7'b1 << (k % 7);
      press(1'b1, 1'b0, 12);
      check("wrap_walk", 32'(st), 32'(exp_st));
    end
    check("wrap_pulses", 32'(pulse_cnt - base), 32'd7);

    press(1'b0, 1'b1, 12);
    check("back_wrap", 32'(st), 32'h40);

    base = pulse_cnt;
    press(1'b1, 1'b1, 12);
    check("simul_state", 32'(st), 32'h40);
    check("simul_pulses", 32'(pulse_cnt - base), 32'd0);

    press(1'b1, 1'b0, 12);
    check("back_to_s0", 32'(st), 32'h01);

    // Auto mode: sync at edge 2, first step at edge 12, next at edge 22.
    auto_en = 1'b1;
    wait_cyc(11);
    check("auto_before", 32'(st), 32'h01);
    wait_cyc(1);
    check("auto_s1", 32'(st), 32'h02);
    wait_cyc(9);
    check("auto_hold_s1", 32'(st), 32'h02);
    key_next_n = 1'b0;
    wait_cyc(1);
    check("auto_s2", 32'(st), 32'h04);
    // Press event lands while timer = 6 (edge 28), state moves at edge 29.
    wait_cyc(6);
    check("press_before", 32'(st), 32'h04);
    wait_cyc(1);
    check("press_s3", 32'(st), 32'h08);
    key_next_n = 1'b1;
    wait_cyc(9);
    check("auto_restart_hold", 32'(st), 32'h08);
    wait_cyc(1);
    check("auto_restart_s4", 32'(st), 32'h10);
    auto_en = 1'b0;
    wait_cyc(5);
    check("auto_off", 32'(st), 32'h10);

    // Corrupt the state register and expect silent recovery to S0.
    base = pulse_cnt;
    force dut.state_q = 7'b0000101;
    #1 release dut.state_q;
    wait_cyc(1);
    check("recover_state", 32'(st), 32'h01);
    wait_cyc(1);
    check("recover_pulse", 32'(step_pulse), 32'h0);
    check("recover_pulses", 32'(pulse_cnt - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Seven-state one-hot sequencer that drives the state-to-hex display decoder directly. Its state_0..state_6 outputs feed that decoder's seven one-hot state inputs bit-for-bit.
- Steps forward or backward on conditioned pushbutton presses. Optionally auto-advances on a fixed interval.
- Top-level board block: raw buttons and a switch in, one-hot state out.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
- STEP_CYCLES, 50000000, auto-advance interval in clock cycles (1 s at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_next_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- key_back_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- auto_en  input  1  slide switch; 1 enables timed auto-advance. Asynchronous to clk.
- state_0 .. state_6  output  1 each  registered one-hot state; state_k=1 means state Sk.
- step_pulse  output  1  one-cycle strobe, high in the cycle after any state change.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state_0=1, state_1..state_6=0, step_pulse=0.
  - Debounce counters, step timer and synchronizers all cleared.
  - Conditioned button levels reset to "released".
- Input conditioning, per button and for auto_en:
  - 2-flop synchronizer, reset to the inactive level.
  - Debounce per button: counter (width clog2(DEBOUNCE_CYCLES+1)) increments while the synchronized level differs from the accepted level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears.
  - A press event (next_evt / back_evt) is a single-cycle pulse on the released->pressed transition of the accepted level only. Releases produce no event.
- State machine: states S0..S6, one-hot encoded.
  - next_evt only: Sk -> S(k+1); S6 wraps to S0.
  - back_evt only: Sk -> S(k-1); S0 wraps to S6.
  - next_evt and back_evt in the same cycle: hold state, no step_pulse.
- Auto mode:
  - Step timer counts 0..STEP_CYCLES-1 while synchronized auto_en=1.
  - At terminal count it generates auto_evt and wraps to 0. auto_evt behaves as next_evt.
  - auto_en=0 holds the timer at 0.
  - Any accepted button event clears the timer, so the next auto step occurs STEP_CYCLES after the press.
  - auto_evt coincident with a button event is ignored; the button wins.
- Latency:
  - Raw press to state change: 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 register.
  - State register to step_pulse: +1 cycle.
- Robustness: if the state register is ever not exactly one-hot (zero or more than one bit set), the next cycle forces S0. No step_pulse is issued for this recovery.
- Reset mid-operation: asserting rst_n low at any cycle returns to S0 immediately; a button held through reset produces no event until it is released and pressed again.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_pkg holds:
  - NUM_STATES = 7.
  - typedef state_oh_t (7-bit one-hot).
  - Constants S0_OH..S6_OH.
  - Function is_onehot.
- One sub-module: button_conditioner (synchronizer + debounce + press-edge pulse, parameter DEBOUNCE_CYCLES). Instantiated once per key.
- auto_en uses a bare 2-flop synchronizer inline.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, STEP_CYCLES=10):
- Reset:
  - Hold rst_n=0 mid-sequence at S3 -> state_0=1, others 0, step_pulse=0 asynchronously.
  - After release, there is no step until a new press.
- Single next press:
  - key_next_n low for 20 cycles -> exactly one transition S0->S1.
  - step_pulse high for exactly 1 cycle.
  - State change occurs 2+4+1+1 = 8 cycles after the falling edge.
- Bounce and wrap:
  - Key toggles every 2 cycles for 12 cycles, then held low: one step only.
  - Seven clean next presses from S0 -> S1..S6, then back to S0.
  - One back press from S0 -> S6.
- Simultaneous presses: both keys pressed on the same cycle -> state unchanged, no step_pulse.
- Auto mode:
  - auto_en=1 from S0 -> S1 after 10 cycles past sync, then S2 after 10 more.
  - A next press at timer count 6 -> state advances once from the press; the next auto step is 10 cycles later.
- One-hot recovery: force the state register to 7'b0000101 -> next cycle state_0=1 only, step_pulse=0.
